// File: rtl/uart_rx_if.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------
// uart_rx_if : serial line and received-byte outputs of uart_rx, rev 1.0
// ---------------------------------------------------------------
interface uart_rx_if;
  logic       rx_wire_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       frame_err_out;
  logic       busy_out;

  modport slave (
    input  rx_wire_in,
    output data_out, valid_out, frame_err_out, busy_out
  );

  modport master (
    output rx_wire_in,
    input  data_out, valid_out, frame_err_out, busy_out
  );
endinterface
`default_nettype wire

// File: rtl/uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------
// uart_rx : 8N1 UART receiver, 2-flop synchronizer, mid-bit sampling, rev 1.0
// ---------------------------------------------------------------
module uart_rx #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 115_200
) (
  input wire       clk_in,
  input wire       rst_in,
  uart_rx_if.slave bus
);

  localparam int BIT_CYC  = CLK_FREQ / BAUD_RATE;
  localparam int HALF_CYC = BIT_CYC / 2;
  localparam int CNT_W    = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYC - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_HIGH = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic             r_sync1;
  logic             r_rx_s;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic [7:0]       r_data;
  logic             r_valid;
  logic             r_ferr;

  logic w_cnt_clr;
  logic w_idx_clr;
  logic w_shift_en;
  logic w_stop_ok;
  logic w_stop_bad;
  logic w_half_hit;
  logic w_bit_hit;

  assign w_half_hit = (r_cnt == HALF_LAST);
  assign w_bit_hit  = (r_cnt == BIT_LAST);

  // Synchronizer idles high so reset never looks like a start bit.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_sync1 <= 1'b1;
      r_rx_s  <= 1'b1;
    end else begin
      r_sync1 <= bus.rx_wire_in;
      r_rx_s  <= r_sync1;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_clr    = 1'b0;
    w_idx_clr    = 1'b0;
    w_shift_en   = 1'b0;
    w_stop_ok    = 1'b0;
    w_stop_bad   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!r_rx_s) begin
          w_cnt_clr    = 1'b1;
          w_state_next = S_START;
        end
      end
      S_START: begin
        if (w_half_hit) begin
          w_cnt_clr    = 1'b1;
          w_idx_clr    = 1'b1;
          w_state_next = r_rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (w_bit_hit) begin
          w_cnt_clr  = 1'b1;
          w_shift_en = 1'b1;
          if (r_bit_idx == 3'd7) w_state_next = S_STOP;
        end
      end
      S_STOP: begin
        if (w_bit_hit) begin
          w_cnt_clr = 1'b1;
          if (r_rx_s) begin
            w_stop_ok    = 1'b1;
            w_state_next = S_IDLE;
          end else begin
            w_stop_bad   = 1'b1;
            w_state_next = S_WAIT_HIGH;
          end
        end
      end
      S_WAIT_HIGH: begin
        if (r_rx_s) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_cnt     <= '0;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'h00;
      r_data    <= 8'h00;
      r_valid   <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      if (w_cnt_clr)
        r_cnt <= '0;
      else if (r_state == S_START || r_state == S_DATA || r_state == S_STOP)
        r_cnt <= r_cnt + CNT_W'(1);

      if (w_idx_clr)       r_bit_idx <= 3'd0;
      else if (w_shift_en) r_bit_idx <= r_bit_idx + 3'd1;

      if (w_shift_en) r_shift <= {r_rx_s, r_shift[7:1]};

      // Strobes land one cycle after the stop sample, with data_out.
      r_valid <= w_stop_ok;
      r_ferr  <= w_stop_bad;
      if (w_stop_ok) r_data <= r_shift;
    end
  end

  assign bus.data_out      = r_data;
  assign bus.valid_out     = r_valid;
  assign bus.frame_err_out = r_ferr;
  assign bus.busy_out      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115_200, serial bit rate in bits/s.
REQ-003 SHALL have port clk_in  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_in  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port rx_wire_in  input  1  asynchronous UART serial line, idle high (computer to FPGA).
REQ-006 SHALL have port data_out  output  8  last correctly framed received byte.
REQ-007 SHALL have port valid_out  output  1  one-cycle strobe: data_out holds a new byte.
REQ-008 SHALL have port frame_err_out  output  1  one-cycle strobe: the stop bit was sampled low.
REQ-009 SHALL have port busy_out  output  1  high whenever the state is not IDLE.

Function
REQ-010 SHALL define BIT_CYC = CLK_FREQ/BAUD_RATE (integer division; 868 at defaults) and HALF_CYC = BIT_CYC/2 (434 at defaults), with the counter width being the minimal width that holds BIT_CYC-1.
REQ-011 SHALL pass rx_wire_in through a 2-flop synchronizer whose flops reset to 1; all logic uses only the synchronized value rx_s.
REQ-012 SHALL implement states IDLE, START, DATA, STOP and WAIT_HIGH.
REQ-013 In IDLE, rx_s=0 SHALL clear the counter and enter START.
REQ-014 In START, rx_s SHALL be sampled when the counter reaches HALF_CYC-1: if rx_s=0, go to DATA with the counter and bit index cleared; if rx_s=1, treat it as a glitch and return to IDLE with no strobe.
REQ-015 In DATA, rx_s SHALL be sampled each time the counter reaches BIT_CYC-1, with the counter then cleared, shifting bits LSB first into an internal shift register.
REQ-016 The eighth data sample SHALL move the block to STOP.
REQ-017 In STOP, rx_s SHALL be sampled when the counter reaches BIT_CYC-1, which is mid stop bit.
REQ-018 If the STOP sample is 1, the next cycle SHALL load data_out from the shift register, pulse valid_out for exactly 1 cycle, and return to IDLE.
REQ-019 If the STOP sample is 0, the next cycle SHALL pulse frame_err_out for 1 cycle, leave data_out unchanged, and enter WAIT_HIGH.
REQ-020 WAIT_HIGH SHALL remain until rx_s=1 and then go to IDLE, so that a break (line held low) never produces a false start.
REQ-021 The total latency from the rx_s falling edge to the STOP sample SHALL be HALF_CYC + 9*BIT_CYC cycles (8246 at defaults).
REQ-022 The strobe SHALL occur one cycle after the STOP sample.
REQ-023 valid_out and frame_err_out SHALL never be high in the same cycle, and each SHALL be high for exactly one cycle per frame.
REQ-024 data_out SHALL hold its value between frames and change only together with valid_out.
REQ-025 A falling edge on the line during DATA or STOP SHALL NOT restart reception.
REQ-026 A new start bit SHALL be accepted in the first IDLE cycle after a good stop, which supports back-to-back frames with no idle gap.
REQ-027 The block SHALL have no flow control: a downstream consumer that is not ready misses the byte, and the block has no internal FIFO.

Reset
REQ-028 On rst_in=1 the block SHALL, asynchronously: set state IDLE, counter 0, bit index 0, shift register 0x00, data_out 0x00, valid_out 0, frame_err_out 0, busy_out 0, and both synchronizer flops 1.
REQ-029 Reset asserted mid-frame SHALL abort the frame with no strobe.
REQ-030 After reset release with the line low, the block SHALL treat the low line as a start bit.

Verification
REQ-031 Bench SHALL cover: frame 0xA5 at defaults -> data_out=0xA5, valid_out high exactly once, 8249 +/- 2 cycles after the rx_wire_in falling edge, busy_out low in the next cycle.
REQ-032 Bench SHALL cover: bytes 0x00, 0xFF, 0x3C sent back-to-back with zero idle time -> three valid_out strobes in order with those values and no frame_err_out.
REQ-033 Bench SHALL cover: a 200-cycle low glitch on an idle line -> return to IDLE after 436 +/- 2 cycles, with no strobe and data_out unchanged.
REQ-034 Bench SHALL cover: frame 0x5A with the stop bit driven low, then the line held low for 3 bit times -> one frame_err_out pulse, no valid_out, data_out keeps its previous value, the block stays in WAIT_HIGH until the line rises, and the next frame 0x81 is received correctly.
REQ-035 Bench SHALL cover: rst_in pulsed during data bit 4 of a frame -> all outputs at reset values immediately, no strobe for that frame, and the following frame 0x42 is received correctly.
REQ-036 Bench SHALL cover: line baud offset of +2% and -2% from BAUD_RATE over 16 random bytes -> all bytes are received correctly.
